// File: rtl/avalon_mem_responder.sv
// Avalon-MM memory responder: a word-addressed RAM behind a waitrequest
// handshake. Reads return after a fixed pipelined latency, flagged by
// readdatavalid.
//
// Ports:
//   clk, rst            - system clock, synchronous active-high reset
//   slave_address       - byte address; word index = [ADDR_W+1:2]
//   slave_read/write    - request strobes, held while waitrequest = 1
//   slave_writedata     - write data
//   slave_waitrequest   - registered; 0 marks the accepting cycle
//   slave_readdata      - read data, updated together with readdatavalid
//   slave_readdatavalid - one-cycle pulse per completed read
//   rd_count, wr_count  - accepted access counters (MEM_STATS_EN only)
//   err_sticky          - read+write collision or out-of-range access seen
//
// Optional feature macro: MEM_STATS_EN adds saturating rd_count/wr_count.
module avalon_mem_responder #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned RD_LATENCY  = 2,
    parameter logic [31:0] OOR_DATA    = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] slave_address,
    input  logic        slave_read,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    output logic        slave_waitrequest,
    output logic [31:0] slave_readdata,
    output logic        slave_readdatavalid,
`ifdef MEM_STATS_EN
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
`endif
    output logic        err_sticky
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {IDLE, STALL, ACCEPT} state_t;

    state_t             state;
    logic [CNT_W-1:0]   stall_cnt;
    logic [31:0]        mem [DEPTH];

    logic [ADDR_W-1:0]  word_idx_c;
    logic               in_range_c;
    logic               req_c;
    logic               accept_c;
    logic               do_write_c;
    logic               do_read_c;
    logic               unused_addr_lsb;

    logic               pipe_vld [RD_LATENCY];
    logic [ADDR_W-1:0]  pipe_idx [RD_LATENCY];
    logic               pipe_inr [RD_LATENCY];

    assign word_idx_c      = slave_address[ADDR_W+1:2];
    assign in_range_c      = (slave_address[31:ADDR_W+2] == '0);
    assign req_c           = slave_read | slave_write;
    assign accept_c        = (state == ACCEPT);
    // A write always wins a read/write collision; the read is discarded.
    assign do_write_c      = accept_c & slave_write;
    assign do_read_c       = accept_c & slave_read & ~slave_write;
    assign unused_addr_lsb = ^slave_address[1:0];

    // Handshake FSM; waitrequest is decoded from the next state so it stays registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            stall_cnt         <= '0;
            slave_waitrequest <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req_c) begin
                        if (WAIT_CYCLES == 0) begin
                            state             <= ACCEPT;
                            slave_waitrequest <= 1'b0;
                        end else begin
                            state     <= STALL;
                            stall_cnt <= CNT_W'(WAIT_CYCLES - 1);
                        end
                    end
                end
                STALL: begin
                    if (!req_c) begin
                        state <= IDLE;
                    end else if (stall_cnt == '0) begin
                        state             <= ACCEPT;
                        slave_waitrequest <= 1'b0;
                    end else begin
                        stall_cnt <= stall_cnt - CNT_W'(1);
                    end
                end
                ACCEPT: begin
                    state             <= IDLE;
                    slave_waitrequest <= 1'b1;
                end
                default: begin
                    state             <= IDLE;
                    slave_waitrequest <= 1'b1;
                end
            endcase
        end
    end

    // Storage; deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (do_write_c && in_range_c && !rst) begin
            mem[word_idx_c] <= slave_writedata;
        end
    end

    // Read pipeline carries the word index; data is fetched at the output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                pipe_vld[i] <= 1'b0;
                pipe_idx[i] <= '0;
                pipe_inr[i] <= 1'b0;
            end
            slave_readdatavalid <= 1'b0;
            slave_readdata      <= '0;
        end else begin
            pipe_vld[0] <= do_read_c;
            pipe_idx[0] <= word_idx_c;
            pipe_inr[0] <= in_range_c;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
                pipe_inr[i] <= pipe_inr[i-1];
            end
            slave_readdatavalid <= pipe_vld[RD_LATENCY-1];
            if (pipe_vld[RD_LATENCY-1]) begin
                slave_readdata <= pipe_inr[RD_LATENCY-1] ? mem[pipe_idx[RD_LATENCY-1]]
                                                         : OOR_DATA;
            end
        end
    end

    // Sticky error: collision or out-of-range on an accepted access.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky <= 1'b0;
        end else if (accept_c && req_c &&
                     (!in_range_c || (slave_read && slave_write))) begin
            err_sticky <= 1'b1;
        end
    end

`ifdef MEM_STATS_EN
    // Saturating access counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (do_read_c && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
            if (do_write_c && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_avalon_mem_responder.sv
// Bench for avalon_mem_responder: instance a uses default parameters,
// instance p uses WAIT_CYCLES=0 / RD_LATENCY=4. Expected read results are
// queued at acceptance and compared when readdatavalid appears.
module tb_avalon_mem_responder;

    localparam int A_LAT = 2;
    localparam int P_LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a_addr, a_wdata, a_rdata, p_addr, p_wdata, p_rdata;
    logic        a_rd, a_wr, a_wait, a_rdv, a_err;
    logic        p_rd, p_wr, p_wait, p_rdv, p_err;
`ifdef MEM_STATS_EN
    logic [15:0] a_rdc, a_wrc, p_rdc, p_wrc;
`endif

    always #5 clk = ~clk;

    avalon_mem_responder dut_a (
        .clk(clk), .rst(rst),
        .slave_address(a_addr), .slave_read(a_rd), .slave_write(a_wr),
        .slave_writedata(a_wdata), .slave_waitrequest(a_wait),
        .slave_readdata(a_rdata), .slave_readdatavalid(a_rdv),
`ifdef MEM_STATS_EN
        .rd_count(a_rdc), .wr_count(a_wrc),
`endif
        .err_sticky(a_err)
    );

    avalon_mem_responder #(.WAIT_CYCLES(0), .RD_LATENCY(P_LAT)) dut_p (
        .clk(clk), .rst(rst),
        .slave_address(p_addr), .slave_read(p_rd), .slave_write(p_wr),
        .slave_writedata(p_wdata), .slave_waitrequest(p_wait),
        .slave_readdata(p_rdata), .slave_readdatavalid(p_rdv),
`ifdef MEM_STATS_EN
        .rd_count(p_rdc), .wr_count(p_wrc),
`endif
        .err_sticky(p_err)
    );

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        qa[$];
    exp_t        qp[$];
    logic [31:0] mdl_a [1024];
    logic [31:0] mdl_p [1024];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_bad = 0;
    int          a_nrd = 0;
    int          a_nwr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: compare each readdatavalid pulse with the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (a_rdv === 1'b1) begin
            if (qa.size() == 0) check_val("a_spurious_rdv", 32'd1, 32'd0);
            else begin
                e = qa.pop_front();
                check_val("a_rdata", a_rdata, e.data);
                check_val("a_rd_cycle", 32'(cyc), 32'(e.due));
            end
        end
        if (p_rdv === 1'b1) begin
            if (qp.size() == 0) check_val("p_spurious_rdv", 32'd1, 32'd0);
            else begin
                e = qp.pop_front();
                check_val("p_rdata", p_rdata, e.data);
                check_val("p_rd_cycle", 32'(cyc), 32'(e.due));
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        a_rd = 0; a_wr = 0; a_addr = 0; a_wdata = 0;
        p_rd = 0; p_wr = 0; p_addr = 0; p_wdata = 0;
        qa.delete();
        qp.delete();
        a_nrd = 0;
        a_nwr = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One Avalon transfer; returns the number of cycles waitrequest was high.
    task automatic xfer(input bit sel, input logic [31:0] addr, input bit rd, input bit wr,
                        input logic [31:0] data, output int waits);
        bit          done;
        bit          inr;
        logic [9:0]  idx;
        logic [31:0] hi;
        exp_t        e;
        done  = 1'b0;
        waits = 0;
        hi    = addr >> 12;
        inr   = (hi == 32'd0);
        idx   = addr[11:2];
        if (sel) begin p_addr = addr; p_rd = rd; p_wr = wr; p_wdata = data; end
        else     begin a_addr = addr; a_rd = rd; a_wr = wr; a_wdata = data; end
        while (!done) begin
            @(negedge clk);
            if ((sel ? p_wait : a_wait) == 1'b0) done = 1'b1;
            else waits++;
            if (waits > 50) begin
                check_val("handshake_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        if (done) begin
            if (wr) begin
                if (inr) begin
                    if (sel) mdl_p[idx] = data;
                    else     mdl_a[idx] = data;
                end
                if (!sel) a_nwr++;
            end else if (rd) begin
                e.data = inr ? (sel ? mdl_p[idx] : mdl_a[idx]) : 32'hDEADBEEF;
                e.due  = cyc + (sel ? P_LAT : A_LAT);
                if (sel) qp.push_back(e);
                else     qa.push_back(e);
                if (!sel) a_nrd++;
            end
        end
        if (sel) begin p_rd = 0; p_wr = 0; end
        else     begin a_rd = 0; a_wr = 0; end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (qa.size() != 0 || qp.size() != 0); i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        do_reset();
        check_val("rst_waitrequest", 32'(a_wait), 32'd1);
        check_val("rst_rdv", 32'(a_rdv), 32'd0);
        check_val("rst_rdata", a_rdata, 32'd0);
        check_val("rst_err", 32'(a_err), 32'd0);
        check_val("rst_p_waitrequest", 32'(p_wait), 32'd1);

        // Write then read back; waitrequest high for IDLE + STALL.
        xfer(0, 32'h0, 0, 1, 32'h5, w);
        check_val("wr_wait_cycles", 32'(w), 32'd2);
        xfer(0, 32'h0, 1, 0, 32'h0, w);
        check_val("rd_wait_cycles", 32'(w), 32'd2);
        drain();

        // Sorter-style swap.
        xfer(0, 32'h4, 0, 1, 32'h1, w);
        xfer(0, 32'h8, 0, 1, 32'h0, w);
        xfer(0, 32'h4, 1, 0, 32'h0, w);
        xfer(0, 32'h8, 1, 0, 32'h0, w);
        xfer(0, 32'h4, 0, 1, 32'h0, w);
        xfer(0, 32'h8, 0, 1, 32'h1, w);
        xfer(0, 32'h4, 1, 0, 32'h0, w);
        xfer(0, 32'h8, 1, 0, 32'h0, w);
        drain();
        check_val("swap_err", 32'(a_err), 32'd0);
        check_val("swap_drained", 32'(qa.size()), 32'd0);

        // Pipelined reads on the zero-wait, latency-4 instance.
        for (int i = 0; i < 4; i++) xfer(1, 32'(32'h10 + 4 * i), 0, 1, 32'(i * 7 + 3), w);
        check_val("p_wait_cycles", 32'(w), 32'd1);
        for (int i = 0; i < 4; i++) xfer(1, 32'(32'h10 + 4 * i), 1, 0, 32'h0, w);
        drain();
        check_val("p_err", 32'(p_err), 32'd0);

        // Out-of-range read and write; the write must not alias onto word 0.
        xfer(0, 32'h0000_1000, 1, 0, 32'h0, w);
        drain();
        check_val("oor_err", 32'(a_err), 32'd1);
        xfer(0, 32'h0000_1000, 0, 1, 32'h1234_5678, w);
        xfer(0, 32'h0, 1, 0, 32'h0, w);
        drain();

        // Simultaneous read and write: write wins, no readdatavalid.
        do_reset();
        check_val("rst2_err", 32'(a_err), 32'd0);
        xfer(0, 32'hC, 1, 1, 32'h7, w);
        drain();
        check_val("rw_err", 32'(a_err), 32'd1);
        xfer(0, 32'hC, 1, 0, 32'h0, w);
        drain();

`ifdef MEM_STATS_EN
        check_val("rd_count", 32'(a_rdc), 32'(a_nrd));
        check_val("wr_count", 32'(a_wrc), 32'(a_nwr));
`endif

        // Reset one cycle after a read accept: the read must vanish.
        xfer(0, 32'h8, 1, 0, 32'h0, w);
        do_reset();
        repeat (8) @(posedge clk);
        #1;
        check_val("midrst_rdv", 32'(a_rdv), 32'd0);
`ifdef MEM_STATS_EN
        check_val("midrst_rd_count", 32'(a_rdc), 32'd0);
`endif
        xfer(0, 32'h8, 1, 0, 32'h0, w);
        xfer(0, 32'hC, 1, 0, 32'h0, w);
        drain();

        check_val("final_qa_empty", 32'(qa.size()), 32'd0);
        check_val("final_qp_empty", 32'(qp.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
